dispatch_credit_ctrl: RTL and testbench
=======================================

Name: dispatch_credit_ctrl

Overview:
- Sits between Rename and the integer/mem/FP issue queues.
- Tracks free-entry credits per issue queue and grants all-or-nothing dispatch of each renamed group.
- Asserts stall back into Rename when any valid slot's target queue lacks credit.
- Resynchronises credits from queue occupancy after a branch-mispredict flush, using a small recovery state machine.

Parameters:
- WIDTH_ISSUE, 4, number of rename/dispatch slots per cycle
- NUM_IQ, 4, number of issue queues
- IQ_DEPTH, 8, entries per issue queue (all queues equal)
- CNT_W, 4, credit counter width; must satisfy 2^CNT_W > IQ_DEPTH

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- IN_uopValid[WIDTH_ISSUE]  in  1  slot holds a renamed uop this cycle
- IN_uopIQ[WIDTH_ISSUE]  in  $clog2(NUM_IQ)  target queue of slot
- IN_stall  in  1  downstream stall; no dispatch this cycle
- IN_iqFree[NUM_IQ]  in  2  entries issued/freed by queue q this cycle (0..2)
- IN_branchTaken  in  1  mispredict pulse; queues begin flushing younger entries
- IN_iqFlushDone  in  1  all queues finished flushing; IN_iqOcc valid
- IN_iqOcc[NUM_IQ]  in  CNT_W  post-flush occupancy of queue q
- OUT_dispValid[WIDTH_ISSUE]  out  1  slot dispatched this cycle
- OUT_stall  out  1  group not accepted; Rename must hold
- OUT_credits[NUM_IQ]  out  CNT_W  registered free-credit count per queue
- OUT_err  out  1  sticky: credit overflow or underflow detected

Behaviour:
- States: RUN, RECOVER. Reset (rst=0 at posedge) → RUN, credits[q]=IQ_DEPTH, OUT_err=0. OUT_dispValid and OUT_stall are combinational; with all inputs idle they are 0 in reset.
- RUN demand: need[q] = count of valid slots with IN_uopIQ==q.
- RUN fit: fit = need[q] <= credits[q] for all q, evaluated on registered credits only. Same-cycle frees are not bypassed.
- RUN dispatch: dispatch = fit && !IN_stall && !IN_branchTaken. OUT_dispValid[i] = dispatch && IN_uopValid[i]. No partial groups.
- RUN stall: OUT_stall = IN_stall || (any valid slot && !fit).
- RUN update: credits[q] <= credits[q] - (dispatch ? need[q] : 0) + IN_iqFree[q]. Zero-latency free is invisible until the next cycle.
- Overflow: if the update result exceeds IQ_DEPTH, clamp to IQ_DEPTH and set OUT_err.
- Underflow: OUT_err is also set if the subtrahend exceeds credits[q] plus free. This cannot happen with correct fit.
- IN_branchTaken in RUN → RECOVER next cycle. Dispatch is suppressed that cycle; frees are still applied but are irrelevant.
- RECOVER: OUT_stall=1, OUT_dispValid=0, IN_iqFree ignored.
- RECOVER exit: on IN_iqFlushDone=1, credits[q] <= IQ_DEPTH - IN_iqOcc[q] and go to RUN. Dispatch is possible the following cycle.
- IN_iqOcc includes that cycle's frees, so frees are ignored that cycle.
- IN_iqOcc[q] > IQ_DEPTH: set OUT_err and load credits[q]=0.
- IN_branchTaken in RECOVER: stay in RECOVER. If it coincides with IN_iqFlushDone, the flush-done is discarded and the controller waits for a fresh IN_iqFlushDone.
- IN_iqFlushDone in RUN is ignored.
- Reset mid-RECOVER → RUN with full credits, the same as power-on.
- Group with no valid slots: OUT_stall = IN_stall. Credits change only by frees.
- Multiple slots to one queue: need counts all of them, e.g. 4 slots to q0 need 4 credits.

Test Plan:
- Reset, all 4 slots → q0 for 2 cycles, no frees → cycle1 dispatch all (credits[0]=4), cycle2 dispatch all (0), cycle3 OUT_stall=1, OUT_dispValid=0.
- credits[1]=1, slots 0,1 → q1, IN_iqFree[1]=2 same cycle → OUT_stall=1 this cycle; next cycle credits[1]=3, group dispatches, credits[1]=1.
- Mixed group q0,q1,q2,q3 with credits 1,1,1,0 → whole group stalls (no partial), credits unchanged; IN_iqFree[3]=1 → next cycle dispatches, credits 0,0,0,0.
- IN_branchTaken, then 3 idle cycles, IN_iqFlushDone with IN_iqOcc={2,0,5,8} → OUT_stall high throughout; next cycle credits={6,8,3,0}, dispatch resumes.
- IN_branchTaken again while in RECOVER coincident with IN_iqFlushDone → remains RECOVER, credits unchanged until the later IN_iqFlushDone.
- Full queue with IN_iqFree[0]=1 forced → credits clamp at 8, OUT_err=1 and stays 1 until rst=0.

Source files
------------

// File: rtl/dispatch_credit_ctrl.sv
// -----------------------------------------------------------------------------
// dispatch_credit_ctrl
//
// Sits between Rename and the issue queues. It keeps one free-entry credit
// counter per issue queue and dispatches a renamed group only when every
// targeted queue has room for the whole group (all-or-nothing). After a
// branch mispredict it waits for the queues to finish flushing, then reloads
// the credits from the reported post-flush occupancy.
//
// Ports:
//   clk            clock
//   rst            synchronous reset, active-low (0 = reset)
//   IN_uopValid    per-slot valid from Rename
//   IN_uopIQ       per-slot target issue queue
//   IN_stall       downstream stall, blocks dispatch this cycle
//   IN_iqFree      per-queue entries freed this cycle (0..2)
//   IN_branchTaken mispredict pulse, starts recovery
//   IN_iqFlushDone queues finished flushing, IN_iqOcc is valid
//   IN_iqOcc       per-queue post-flush occupancy
//   OUT_dispValid  per-slot dispatch grant (combinational)
//   OUT_stall      group not accepted, Rename must hold (combinational)
//   OUT_credits    registered free-credit count per queue
//   OUT_err        sticky credit overflow/underflow flag
// -----------------------------------------------------------------------------
module dispatch_credit_ctrl #(
  parameter int WIDTH_ISSUE = 4,
  parameter int NUM_IQ      = 4,
  parameter int IQ_DEPTH    = 8,
  parameter int CNT_W       = 4,
  localparam int IQ_W       = (NUM_IQ > 1) ? $clog2(NUM_IQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_ISSUE-1:0] IN_uopValid,
  input  logic [IQ_W-1:0]        IN_uopIQ [WIDTH_ISSUE],
  input  logic                   IN_stall,
  input  logic [1:0]             IN_iqFree [NUM_IQ],
  input  logic                   IN_branchTaken,
  input  logic                   IN_iqFlushDone,
  input  logic [CNT_W-1:0]       IN_iqOcc [NUM_IQ],
  output logic [WIDTH_ISSUE-1:0] OUT_dispValid,
  output logic                   OUT_stall,
  output logic [CNT_W-1:0]       OUT_credits [NUM_IQ],
  output logic                   OUT_err
);

  // Demand counter must hold WIDTH_ISSUE; arithmetic width covers
  // credits + free without wrapping so overflow can be detected.
  localparam int NEED_W = $clog2(WIDTH_ISSUE + 1);
  localparam int SUM_W  = ((CNT_W > NEED_W) ? CNT_W : NEED_W) + 2;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] credits_q [NUM_IQ];
  logic [CNT_W-1:0] credits_d [NUM_IQ];
  logic             err_q, err_d;

  logic [NEED_W-1:0] need [NUM_IQ];
  logic              fit;
  logic              any_valid;
  logic              dispatch;

  // Per-queue demand of the current group.
  always_comb begin
    for (int q = 0; q < NUM_IQ; q++) begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      need[q] = '0;
      for (int i = 0; i < WIDTH_ISSUE; i++) begin
        if (IN_uopValid[i] && (IN_uopIQ[i] == IQ_W'(q))) begin
          need[q] = need[q] + NEED_W'(1);
        end
      end
    end
  end

  // Fit uses registered credits only; frees arriving this cycle count next cycle.
  always_comb begin
    fit = 1'b1;
    for (int q = 0; q < NUM_IQ; q++) begin
      if (SUM_W'(need[q]) > SUM_W'(credits_q[q])) begin
        fit = 1'b0;
      end
    end
  end

  assign any_valid     = |IN_uopValid;
  assign dispatch      = (state_q == RUN) && fit && !IN_stall && !IN_branchTaken;
  assign OUT_dispValid = {WIDTH_ISSUE{dispatch}} & IN_uopValid;
  assign OUT_stall     = (state_q == RECOVER) ? 1'b1
                                              : (IN_stall || (any_valid && !fit));

  // Next-state for state, credits and the sticky error flag.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sub;
    logic [SUM_W-1:0] res;
    sum     = '0;
    sub     = '0;
    res     = '0;
    state_d = state_q;
    err_d   = err_q;
    for (int q = 0; q < NUM_IQ; q++) begin
      credits_d[q] = credits_q[q];
    end

    unique case (state_q)
      RUN: begin
        for (int q = 0; q < NUM_IQ; q++) begin
          sum = SUM_W'(credits_q[q]) + SUM_W'(IN_iqFree[q]);
          sub = dispatch ? SUM_W'(need[q]) : '0;
          if (sub > sum) begin
            // Only reachable if fit is broken; flag it and floor at zero.
            err_d        = 1'b1;
            credits_d[q] = '0;
          end else begin
            res = sum - sub;
            if (res > SUM_W'(IQ_DEPTH)) begin
              err_d        = 1'b1;
              credits_d[q] = CNT_W'(IQ_DEPTH);
            end else begin
              credits_d[q] = res[CNT_W-1:0];
            end
          end
        end
        if (IN_branchTaken) begin
          state_d = RECOVER;
        end
      end

      RECOVER: begin
        // A new mispredict restarts the flush, so a coincident flush-done
        // refers to the old flush and is discarded.
        if (!IN_branchTaken && IN_iqFlushDone) begin
          // Occupancy already reflects this cycle's frees, so frees are unused here.
          for (int q = 0; q < NUM_IQ; q++) begin
            if (SUM_W'(IN_iqOcc[q]) > SUM_W'(IQ_DEPTH)) begin
              err_d        = 1'b1;
              credits_d[q] = '0;
            end else begin
              credits_d[q] = CNT_W'(IQ_DEPTH) - IN_iqOcc[q];
            end
          end
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= RUN;
      err_q   <= 1'b0;
      for (int q = 0; q < NUM_IQ; q++) begin
        credits_q[q] <= CNT_W'(IQ_DEPTH);
      end
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      for (int q = 0; q < NUM_IQ; q++) begin
        credits_q[q] <= credits_d[q];
      end
    end
  end

  assign OUT_err = err_q;

  always_comb begin
    for (int q = 0; q < NUM_IQ; q++) begin
      OUT_credits[q] = credits_q[q];
    end
  end

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dispatch_credit_ctrl
//
// Directed bench for dispatch_credit_ctrl. Inputs change 1 ns after the rising
// edge; combinational outputs are checked 1 ns later, registered outputs
// right after the following edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dispatch_credit_ctrl;

  localparam int WIDTH_ISSUE = 4;
  localparam int NUM_IQ      = 4;
  localparam int IQ_DEPTH    = 8;
  localparam int CNT_W       = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       in_uop_valid;
  logic [1:0]       in_uop_iq [WIDTH_ISSUE];
  logic             in_stall;
  logic [1:0]       in_iq_free [NUM_IQ];
  logic             in_branch_taken;
  logic             in_iq_flush_done;
  logic [CNT_W-1:0] in_iq_occ [NUM_IQ];
  logic [3:0]       out_disp_valid;
  logic             out_stall;
  logic [CNT_W-1:0] out_credits [NUM_IQ];
  logic             out_err;

  int n_checks = 0;
  int n_errors = 0;

  dispatch_credit_ctrl #(
    .WIDTH_ISSUE(WIDTH_ISSUE),
    .NUM_IQ     (NUM_IQ),
    .IQ_DEPTH   (IQ_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .IN_uopValid   (in_uop_valid),
    .IN_uopIQ      (in_uop_iq),
    .IN_stall      (in_stall),
    .IN_iqFree     (in_iq_free),
    .IN_branchTaken(in_branch_taken),
    .IN_iqFlushDone(in_iq_flush_done),
    .IN_iqOcc      (in_iq_occ),
    .OUT_dispValid (out_disp_valid),
    .OUT_stall     (out_stall),
    .OUT_credits   (out_credits),
    .OUT_err       (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_credits(input string tag, input int c0, input int c1,
                               input int c2, input int c3);
    check({tag, " cr0"}, int'(out_credits[0]), c0);
    check({tag, " cr1"}, int'(out_credits[1]), c1);
    check({tag, " cr2"}, int'(out_credits[2]), c2);
    check({tag, " cr3"}, int'(out_credits[3]), c3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_uop_valid     = '0;
    in_stall         = 1'b0;
    in_branch_taken  = 1'b0;
    in_iq_flush_done = 1'b0;
    for (int i = 0; i < WIDTH_ISSUE; i++) in_uop_iq[i] = '0;
    for (int q = 0; q < NUM_IQ; q++) begin
      in_iq_free[q] = '0;
      in_iq_occ[q]  = '0;
    end
  endtask

  task automatic set_grp(input logic [3:0] v, input int q0, input int q1,
                         input int q2, input int q3);
    in_uop_valid = v;
    in_uop_iq[0] = 2'(q0);
    in_uop_iq[1] = 2'(q1);
    in_uop_iq[2] = 2'(q2);
    in_uop_iq[3] = 2'(q3);
  endtask

  task automatic set_occ(input int o0, input int o1, input int o2, input int o3);
    in_iq_occ[0] = CNT_W'(o0);
    in_iq_occ[1] = CNT_W'(o1);
    in_iq_occ[2] = CNT_W'(o2);
    in_iq_occ[3] = CNT_W'(o3);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    drive_idle();
    tick();
    tick();
    check("rst stall", int'(out_stall), 0);
    check("rst disp", int'(out_disp_valid), 0);
    check("rst err", int'(out_err), 0);
    check_credits("rst", 8, 8, 8, 8);
    rst = 1'b1;

    // Four slots to q0 for two cycles, then out of credit
    set_grp(4'hF, 0, 0, 0, 0);
    #1;
    check("q0 c1 disp", int'(out_disp_valid), 15);
    check("q0 c1 stall", int'(out_stall), 0);
    tick();
    check("q0 c1 cr0", int'(out_credits[0]), 4);
    #1;
    check("q0 c2 disp", int'(out_disp_valid), 15);
    tick();
    check("q0 c2 cr0", int'(out_credits[0]), 0);
    #1;
    check("q0 c3 stall", int'(out_stall), 1);
    check("q0 c3 disp", int'(out_disp_valid), 0);
    tick();
    check("q0 c3 cr0", int'(out_credits[0]), 0);

    // Bring q1 down to 1, then same-cycle free is not bypassed
    set_grp(4'hF, 1, 1, 1, 1);
    tick();
    check("q1 a cr1", int'(out_credits[1]), 4);
    set_grp(4'h7, 1, 1, 1, 1);
    tick();
    check("q1 b cr1", int'(out_credits[1]), 1);
    set_grp(4'h3, 1, 1, 0, 0);
    in_iq_free[1] = 2'd2;
    #1;
    check("nobyp stall", int'(out_stall), 1);
    check("nobyp disp", int'(out_disp_valid), 0);
    tick();
    check("nobyp cr1", int'(out_credits[1]), 3);
    in_iq_free[1] = 2'd0;
    #1;
    check("free disp", int'(out_disp_valid), 3);
    check("free stall", int'(out_stall), 0);
    tick();
    check("free cr1", int'(out_credits[1]), 1);

    // Build credits {1,1,1,0}, then mixed group stalls whole
    set_grp(4'hF, 2, 2, 2, 2);
    in_iq_free[0] = 2'd1;
    tick();
    check_credits("mix a", 1, 1, 4, 8);
    in_iq_free[0] = 2'd0;
    set_grp(4'hF, 2, 2, 2, 3);
    tick();
    check_credits("mix b", 1, 1, 1, 7);
    set_grp(4'hF, 3, 3, 3, 3);
    tick();
    set_grp(4'h7, 3, 3, 3, 3);
    tick();
    check_credits("mix c", 1, 1, 1, 0);
    set_grp(4'hF, 0, 1, 2, 3);
    in_iq_free[3] = 2'd1;
    #1;
    check("mix stall", int'(out_stall), 1);
    check("mix nopart", int'(out_disp_valid), 0);
    tick();
    check_credits("mix held", 1, 1, 1, 1);
    in_iq_free[3] = 2'd0;
    #1;
    check("mix disp", int'(out_disp_valid), 15);
    tick();
    check_credits("mix done", 0, 0, 0, 0);

    // Mispredict recovery
    drive_idle();
    in_branch_taken = 1'b1;
    #1;
    check("br run stall", int'(out_stall), 0);
    tick();
    in_branch_taken = 1'b0;
    set_grp(4'hF, 0, 0, 0, 0);
    for (int q = 0; q < NUM_IQ; q++) in_iq_free[q] = 2'd2;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rec stall", int'(out_stall), 1);
      check("rec disp", int'(out_disp_valid), 0);
      tick();
      check("rec nofree cr1", int'(out_credits[1]), 0);
    end
    in_iq_flush_done = 1'b1;
    set_occ(2, 0, 5, 8);
    #1;
    check("fd stall", int'(out_stall), 1);
    tick();
    in_iq_flush_done = 1'b0;
    for (int q = 0; q < NUM_IQ; q++) in_iq_free[q] = 2'd0;
    set_occ(0, 0, 0, 0);
    check_credits("reload", 6, 8, 3, 0);
    #1;
    check("resume disp", int'(out_disp_valid), 15);
    check("resume stall", int'(out_stall), 0);
    tick();
    check("resume cr0", int'(out_credits[0]), 2);

    // Branch coincident with flush-done in RECOVER is discarded
    drive_idle();
    in_branch_taken = 1'b1;
    tick();
    in_branch_taken = 1'b0;
    tick();
    in_branch_taken  = 1'b1;
    in_iq_flush_done = 1'b1;
    set_occ(1, 2, 3, 4);
    tick();
    in_branch_taken  = 1'b0;
    in_iq_flush_done = 1'b0;
    check_credits("rebr held", 2, 8, 3, 0);
    #1;
    check("rebr stall", int'(out_stall), 1);
    tick();
    check("rebr stall2", int'(out_stall), 1);
    in_iq_flush_done = 1'b1;
    tick();
    in_iq_flush_done = 1'b0;
    check_credits("rebr reload", 7, 6, 5, 4);
    #1;
    check("rebr run", int'(out_stall), 0);

    // Flush-done in RUN is ignored
    in_iq_flush_done = 1'b1;
    set_occ(8, 8, 8, 8);
    tick();
    in_iq_flush_done = 1'b0;
    check_credits("fd in run", 7, 6, 5, 4);

    // Downstream stall blocks a fitting group
    set_grp(4'hF, 0, 1, 2, 3);
    in_stall = 1'b1;
    #1;
    check("dstall disp", int'(out_disp_valid), 0);
    check("dstall stall", int'(out_stall), 1);
    tick();
    check_credits("dstall", 7, 6, 5, 4);
    drive_idle();

    // Overflow clamp and sticky error
    in_iq_free[0] = 2'd1;
    tick();
    check("full cr0", int'(out_credits[0]), 8);
    check("full err", int'(out_err), 0);
    tick();
    check("ovf cr0", int'(out_credits[0]), 8);
    check("ovf err", int'(out_err), 1);
    in_iq_free[0] = 2'd0;
    tick();
    tick();
    check("ovf sticky", int'(out_err), 1);

    // Reset mid-RECOVER
    in_branch_taken = 1'b1;
    tick();
    in_branch_taken = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_credits("rst rec", 8, 8, 8, 8);
    check("rst rec err", int'(out_err), 0);
    #1;
    check("rst rec stall", int'(out_stall), 0);
    set_grp(4'hF, 0, 0, 0, 0);
    #1;
    check("rst rec disp", int'(out_disp_valid), 15);
    tick();
    check("rst rec cr0", int'(out_credits[0]), 4);

    // Occupancy above depth loads zero and flags error
    drive_idle();
    in_branch_taken = 1'b1;
    tick();
    in_branch_taken  = 1'b0;
    in_iq_flush_done = 1'b1;
    set_occ(9, 0, 0, 0);
    tick();
    drive_idle();
    check_credits("occ bad", 0, 8, 8, 8);
    check("occ bad err", int'(out_err), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
